// File: rtl/cam_table_mgr.sv
// Key-level insert/delete manager for the block-RAM CAM: looks keys up, allocates
// or releases slots, runs the CAM write/busy handshake and tracks occupancy.
module cam_table_mgr #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [DATA_WIDTH-1:0] req_key,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [ADDR_WIDTH:0]   entry_count,
    output logic                  table_full,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr
);
    localparam int ENTRIES = 2 ** ADDR_WIDTH;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_DUP      = 2'b01;
    localparam logic [1:0] ST_FULL     = 2'b10;
    localparam logic [1:0] ST_NOTFOUND = 2'b11;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // rsp_valid and its payload stay put until rsp_ready is seen.
    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP_1, S_LOOKUP_2, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_RESP
    } state_t;

    state_t                  state, state_nx;
    logic                    op_q;
    logic [DATA_WIDTH-1:0]   key_q;
    logic [ENTRIES-1:0]      bitmap;
    logic [ADDR_WIDTH-1:0]   free_slot;
    logic                    bitmap_full;
    logic [ADDR_WIDTH:0]     count_q;

    assign cam_write_data   = key_q;
    assign cam_compare_data = key_q;
    assign entry_count      = count_q;
    assign table_full       = (count_q == (ADDR_WIDTH + 1)'(ENTRIES));
    assign bitmap_full      = &bitmap;

    // Lowest clear bit wins: scanning downward leaves the smallest index last.
    always_comb begin
        free_slot = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!bitmap[i]) free_slot = ADDR_WIDTH'(i);
        end
    end

    always_comb begin
        state_nx         = state;
        req_ready        = 1'b0;
        cam_write_enable = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = S_LOOKUP_1;
            end
            S_LOOKUP_1: state_nx = S_LOOKUP_2;
            S_LOOKUP_2: begin
                if (!op_q) state_nx = (cam_match || bitmap_full) ? S_RESP : S_ISSUE;
                else       state_nx = cam_match ? S_ISSUE : S_RESP;
            end
            S_ISSUE: begin
                if (!cam_write_busy) begin
                    cam_write_enable = 1'b1;
                    state_nx         = S_WAIT_HI;
                end
            end
            S_WAIT_HI: if (cam_write_busy)  state_nx = S_WAIT_LO;
            S_WAIT_LO: if (!cam_write_busy) state_nx = S_RESP;
            S_RESP:    if (rsp_ready)       state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            op_q             <= 1'b0;
            key_q            <= '0;
            bitmap           <= '0;
            count_q          <= '0;
            cam_write_addr   <= '0;
            cam_write_delete <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_status       <= ST_OK;
            rsp_addr         <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        key_q <= req_key;
                    end
                end
                S_LOOKUP_2: begin
                    if (!op_q && cam_match) begin
                        rsp_status <= ST_DUP;
                        rsp_addr   <= cam_match_addr;
                        rsp_valid  <= 1'b1;
                    end else if (!op_q && bitmap_full) begin
                        rsp_status <= ST_FULL;
                        rsp_addr   <= '0;
                        rsp_valid  <= 1'b1;
                    end else if (!op_q) begin
                        cam_write_addr   <= free_slot;
                        cam_write_delete <= 1'b0;
                    end else if (!cam_match) begin
                        rsp_status <= ST_NOTFOUND;
                        rsp_addr   <= '0;
                        rsp_valid  <= 1'b1;
                    end else begin
                        cam_write_addr   <= cam_match_addr;
                        cam_write_delete <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!cam_write_busy) begin
                        bitmap[cam_write_addr] <= !cam_write_delete;
                        // Only count real transitions so a stale bit can never skew occupancy.
                        if (!cam_write_delete && !bitmap[cam_write_addr])
                            count_q <= count_q + 1'b1;
                        else if (cam_write_delete && bitmap[cam_write_addr])
                            count_q <= count_q - 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!cam_write_busy) begin
                        rsp_status <= ST_OK;
                        rsp_addr   <= cam_write_addr;
                        rsp_valid  <= 1'b1;
                    end
                end
                S_RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_table_mgr.sv
// Self-checking bench: behavioural CAM device plus a slot-array reference model of the table.
module tb_cam_table_mgr;
    localparam int DW = 64;
    localparam int AW = 2;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_op = 1'b0;
    logic [DW-1:0] req_key = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_status;
    logic [AW-1:0] rsp_addr;
    logic [AW:0]   entry_count;
    logic          table_full;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_write_data;
    logic          cam_write_delete;
    logic          cam_write_enable;
    logic          cam_write_busy;
    logic [DW-1:0] cam_compare_data;
    logic          cam_match;
    logic [AW-1:0] cam_match_addr;

    int n_cmp = 0;
    int n_err = 0;
    int wt = 2;

    cam_table_mgr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_key(req_key), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_addr(rsp_addr), .entry_count(entry_count),
        .table_full(table_full), .cam_write_addr(cam_write_addr),
        .cam_write_data(cam_write_data), .cam_write_delete(cam_write_delete),
        .cam_write_enable(cam_write_enable), .cam_write_busy(cam_write_busy),
        .cam_compare_data(cam_compare_data), .cam_match(cam_match),
        .cam_match_addr(cam_match_addr)
    );

    always #5 clk = ~clk;

    // CAM device: 32-cycle init sweep after reset, busy for wt cycles after each write.
    logic [DW-1:0] cam_mem [N];
    logic [N-1:0]  cam_vld;
    int            busy_cnt;

    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 32;
            cam_vld  <= '0;
        end else if (cam_write_enable && busy_cnt == 0) begin
            cam_mem[cam_write_addr] <= cam_write_data;
            cam_vld[cam_write_addr] <= !cam_write_delete;
            busy_cnt                <= wt;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign cam_write_busy = (busy_cnt != 0);

    always_comb begin
        cam_match      = 1'b0;
        cam_match_addr = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cam_vld[i] && cam_mem[i] == cam_compare_data) begin
                cam_match      = 1'b1;
                cam_match_addr = AW'(i);
            end
        end
    end

    // Reference model: which key owns each slot.
    logic [DW-1:0] m_key [N];
    bit            m_used [N];

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_used[i] = 0;
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_used[i]) c++;
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_req(input bit op, input logic [DW-1:0] key, input int hold);
        int hit = -1, free = -1, n = 1, t = 0, en_cnt = 0, en_at = 0;
        logic [1:0] e_st;
        logic [AW-1:0] e_ad = '0, w_ad = '0;
        logic [DW-1:0] w_data = '0;
        bit e_wr = 0, e_del = 0, w_del = 0, cam_idle;
        for (int i = 0; i < N; i++) if (m_used[i] && m_key[i] == key && hit < 0) hit = i;
        for (int i = 0; i < N; i++) if (!m_used[i] && free < 0) free = i;
        if (!op) begin
            if (hit >= 0)      begin e_st = 2'b01; e_ad = AW'(hit); end
            else if (free < 0) begin e_st = 2'b10; end
            else               begin e_st = 2'b00; e_ad = AW'(free); e_wr = 1; end
        end else begin
            if (hit >= 0) begin e_st = 2'b00; e_ad = AW'(hit); e_wr = 1; e_del = 1; end
            else          begin e_st = 2'b11; end
        end

        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_key = key;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        if (!req_ready) begin
            check("req_timeout", 1, 0);
            req_valid = 1'b0;
            return;
        end
        cam_idle = !cam_write_busy;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && n < 300) begin
            if (cam_write_enable) begin
                en_cnt++; en_at = n;
                w_ad = cam_write_addr; w_del = cam_write_delete; w_data = cam_write_data;
                check("we_while_busy", cam_write_busy, 0);
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        check("rsp_status", rsp_status, e_st);
        check("rsp_addr", rsp_addr, e_ad);
        check("we_pulses", en_cnt, e_wr ? 1 : 0);
        if (e_wr) begin
            check("wr_addr", w_ad, e_ad);
            check("wr_delete", w_del, e_del);
            check("wr_data", w_data, key);
            if (cam_idle) begin
                check("we_latency", en_at, 3);
                check("rsp_latency_wr", n, 3 + wt + 2);
            end
        end else begin
            check("rsp_latency", n, 3);
        end
        if (e_wr) begin
            m_used[e_ad] = !e_del;
            m_key[e_ad]  = key;
        end
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_status", rsp_status, e_st);
            check("hold_addr", rsp_addr, e_ad);
            check("hold_req_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("req_ready_back", req_ready, 1);
        check("entry_count", entry_count, model_count());
        check("table_full", table_full, model_count() == N);
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_rsp_addr", rsp_addr, 0);
        check("rst_count", entry_count, 0);
        check("rst_we", cam_write_enable, 0);
        check("rst_wr_addr", cam_write_addr, 0);
        check("rst_wr_del", cam_write_delete, 0);
        check("rst_cmp_data", cam_compare_data, 0);
        rst = 1'b0;

        // Insert during the init sweep, then duplicate
        do_req(0, 64'hA5, 0);
        check("busy_done", cam_write_busy, 0);
        do_req(0, 64'hA5, 0);
        do_req(1, 64'hA5, 0);

        // Fill, overflow, delete/reuse, not-found with a long stall
        wt = 3;
        for (int k = 1; k <= 4; k++) do_req(0, DW'(k), 0);
        do_req(0, 64'd5, 0);
        do_req(1, 64'd2, 0);
        do_req(0, 64'd9, 0);
        do_req(1, 64'd77, 10);

        // Reset while waiting for the CAM write to finish
        wt = 8;
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b1; req_key = 64'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("wait_lo_busy", cam_write_busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_count", entry_count, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_we", cam_write_enable, 0);
        model_clear();
        wt = 2;
        do_req(0, 64'hA5, 0);

        // Randomized mix over a small key pool to hit DUP, FULL and NOTFOUND often
        for (int r = 0; r < 60; r++) begin
            wt = $urandom_range(1, 4);
            do_req(1'($urandom_range(0, 1)), DW'($urandom_range(0, 6)), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
